// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams W[0..63] with a valid/ready handshake.
// Define SCHED_K_OUT_EN to add a registered round-constant output k_out aligned with w_out.
module sha256_msg_schedule #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] blk_in,
    output logic         busy,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   round,
    output logic         done
`ifdef SCHED_K_OUT_EN
    ,
    output logic [31:0]  k_out
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  round_q, round_d;
    logic        xfer;
    logic        last;
    logic [31:0] w_new;

`ifdef SCHED_K_OUT_EN
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    logic [31:0] k_q, k_d;
`endif

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign xfer = (state_q == RUN) && w_ready;
    assign last = (round_q == 6'(ROUNDS - 1));

    // win_q[0] is W[round]; the word entering the tail is W[round+16]
    assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (xfer && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == RUN);
        w_valid = (state_q == RUN);
        done    = (state_q == DONE);
    end

    always_comb begin
        win_d   = win_q;
        round_d = round_q;
`ifdef SCHED_K_OUT_EN
        k_d     = k_q;
`endif
        if (state_q == IDLE && start) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win_d[i] = blk_in[511 - 32*i -: 32];
            end
            round_d = '0;
`ifdef SCHED_K_OUT_EN
            k_d     = K_TAB[0];
`endif
        end else if (xfer) begin
            if (last) begin
                // Clearing here makes w_out read 0 between blocks
                for (int unsigned i = 0; i < 16; i++) begin
                    win_d[i] = '0;
                end
                round_d = '0;
`ifdef SCHED_K_OUT_EN
                k_d     = '0;
`endif
            end else begin
                for (int unsigned i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i + 1];
                end
                win_d[15] = w_new;
                round_d   = round_q + 6'd1;
`ifdef SCHED_K_OUT_EN
                k_d       = K_TAB[round_q + 6'd1];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '{default: '0};
            round_q <= '0;
`ifdef SCHED_K_OUT_EN
            k_q     <= '0;
`endif
        end else begin
            win_q   <= win_d;
            round_q <= round_d;
`ifdef SCHED_K_OUT_EN
            k_q     <= k_d;
`endif
        end
    end

    assign w_out = win_q[0];
    assign round = round_q;
`ifdef SCHED_K_OUT_EN
    assign k_out = k_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized self-checking bench for sha256_msg_schedule against a full 64-word reference schedule.
// Covers the "abc" and all-zero blocks, backpressure, ignored starts, mid-block reset and k_out when enabled.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] blk_in;
    logic         busy;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   round;
    logic         done;
`ifdef SCHED_K_OUT_EN
    logic [31:0]  k_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .blk_in  (blk_in),
        .busy    (busy),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_out   (w_out),
        .round   (round),
        .done    (done)
`ifdef SCHED_K_OUT_EN
        ,
        .k_out   (k_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: full 64-word expansion straight from the SHA-256 recurrence
    task automatic build_model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            logic [31:0] s0, s1;
            s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_w_out"},   w_out,        32'd0);
        chk({tag, "_round"},   32'(round),   32'd0);
`ifdef SCHED_K_OUT_EN
        chk({tag, "_k_out"},   k_out,        32'd0);
`endif
    endtask

    task automatic run_block(input logic [511:0] b, input int stall_at, input int stall_len,
                             input int bogus_at, input int reset_at, input bit rnd_ready);
        int idx = 0;
        int stalls = stall_len;
        int busy_cyc = 0;
        int guard = 0;
        bit rdy;
        build_model(b);
        blk_in  = b;
        start   = 1'b1;
        w_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < 64 && guard < 1000) begin
            guard++;
            if (busy) busy_cyc++;
            if (idx == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk_idle_zero("async_reset");
                rst_n = 1'b1;
                return;
            end
            chk("w_valid", 32'(w_valid), 32'd1);
            chk("busy",    32'(busy),    32'd1);
            chk("done_mid", 32'(done),   32'd0);
            chk("round",   32'(round),   32'(idx));
            chk("w_out",   w_out,        exp_w[idx]);
            got_w[idx] = w_out;
`ifdef SCHED_K_OUT_EN
            if (idx == 0)  chk("k_out_r0",  k_out, 32'h428a2f98);
            if (idx == 1)  chk("k_out_r1",  k_out, 32'h71374491);
            if (idx == 63) chk("k_out_r63", k_out, 32'hc67178f2);
`endif
            start = 1'b0;
            if (idx == bogus_at) begin
                start  = 1'b1;
                blk_in = {16{$urandom()}};
            end
            if (idx == stall_at && stalls > 0) begin
                rdy = 1'b0;
                stalls--;
            end else begin
                rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            w_ready = rdy;
            if (rdy) idx++;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        w_ready = 1'b1;
        if (guard >= 1000) chk("timeout", 32'(idx), 32'd64);
        chk("done_pulse",  32'(done),    32'd1);
        chk("done_busy",   32'(busy),    32'd0);
        chk("done_valid",  32'(w_valid), 32'd0);
        chk("done_round",  32'(round),   32'd0);
`ifdef SCHED_K_OUT_EN
        chk("done_k_out",  k_out,        32'd0);
`endif
        if (stall_len == 0 && !rnd_ready) chk("busy_cycles", 32'(busy_cyc), 32'd64);
        // A start held during DONE must not launch a block
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("after_done_done",  32'(done),    32'd0);
        chk("after_done_valid", 32'(w_valid), 32'd0);
        @(posedge clk); #1;
        chk("start_in_done_ignored", 32'(w_valid), 32'd0);
    endtask

    logic [511:0] abc;
    logic [511:0] rblk;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        w_ready = 1'b0;
        blk_in  = '0;
        abc     = {32'h61626380, 448'h0, 32'h00000018};
        #12;
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_block(abc, -1, 0, -1, -1, 1'b0);
        chk("abc_W0",  got_w[0],  32'h61626380);
        chk("abc_W15", got_w[15], 32'h00000018);
        chk("abc_W16", got_w[16], 32'h61626380);
        chk("abc_W17", got_w[17], 32'h000f0000);
        chk("abc_W18", got_w[18], 32'h7da86405);

        run_block('0, -1, 0, -1, -1, 1'b0);

        run_block(abc, 20, 3, -1, -1, 1'b0);

        run_block(abc, -1, 0, 10, -1, 1'b0);

        run_block(abc, -1, 0, -1, 30, 1'b0);
        @(posedge clk); #1;
        chk_idle_zero("post_reset_idle");
        run_block(abc, -1, 0, -1, -1, 1'b0);
        chk("post_reset_W0", got_w[0], 32'h61626380);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom();
            run_block(rblk, -1, 0, -1, -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule generator. Sits directly upstream of the round `iteration` stage.
- Accepts one 512-bit padded message block and streams W[0..63], one word per accepted transfer, with the matching round index.
- The round index drives the round stage's `select`/K lookup.
- Uses a 16-entry rolling window, so no 64-word storage.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block; fixed at 64 for SHA-256; round counter is 6 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to load `blk_in`; sampled only in IDLE.
- blk_in  in  512  padded block; [511:480] = M0 … [31:0] = M15 (big-endian word order).
- busy  out  1  high from the cycle after start is accepted until `done`.
- w_valid  out  1  `w_out`/`round` hold a valid schedule word.
- w_ready  in  1  downstream accepts the word this cycle.
- w_out  out  32  schedule word W[round].
- round  out  6  index t of `w_out` (0..63).
- done  out  1  one-cycle pulse after W[63] is accepted.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, w_valid=0, done=0, w_out=0, round=0, window cleared. Applies immediately, including mid-block; the partial block is discarded.
- States: IDLE, RUN, DONE.
- IDLE → RUN: on start=1 at edge N.
  - Window[0..15] ← M0..M15; round←0.
  - Cycle N+1: busy=1, w_valid=1, w_out=M0.
- start while busy, or while in DONE: ignored (no queueing).
- Transfer rule: a transfer occurs on an edge where w_valid & w_ready.
  - Without a transfer, w_out and round hold stable; the window does not shift.
  - w_valid never drops mid-block.
- t<16: W[t]=M_t.
- t≥16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32 (carries discarded).
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- On each transfer:
  - Window shifts by one and the new word enters the tail; round increments.
  - The next word is presented on the following cycle.
  - One word per cycle at full throughput (w_ready held 1): W0 at N+1, W63 at N+64.
- Transfer of round 63: next cycle w_valid=0, done=1, busy=0, state DONE.
- DONE → IDLE unconditionally after one cycle.
  - Earliest new start is sampled the cycle after done; the next block's W0 appears 2 cycles after done at the earliest.
- round never wraps within a block. After done it reads 0 until the next block.
- w_out is registered; no combinational path from w_ready to w_out.

Optional Feature:
- Macro: SCHED_K_OUT_EN.
- Defined:
  - Adds output port `k_out` (32 bits): registered SHA-256 constant K[round], aligned with w_out/round and held under stall.
  - Taken from an internal 64-entry constant table (K[0]=0x428A2F98, K[63]=0xC67178F2).
  - Reset value 0; 0 when w_valid=0.
- Undefined: no `k_out` port, no table; the round stage keeps its own K lookup by `round`.

Test Plan:
- "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready=1 → round 0..63 on consecutive cycles.
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
  - done pulses exactly once, one cycle after W63.
- All-zero block → all 64 words 0; busy high exactly 64 cycles.
- Backpressure: w_ready=0 for 3 cycles while round=20 → w_out/round frozen for those cycles; sequence resumes with W20 then W21; final words match the unstalled run.
- start pulsed at round 10 with a different blk_in → ignored; output still matches the first block.
- rst_n asserted at round 30 → all outputs 0 asynchronously. After release, start with the "abc" block → clean W0=0x61626380 at round 0.
- With SCHED_K_OUT_EN: "abc" block → k_out = 0x428A2F98 at round 0, 0x71374491 at round 1, 0xC67178F2 at round 63.
